q_ifid_queue: RTL and testbench

//  Receiving end of the IF->ID push interface: a first-word-fall-through FIFO holding fetch bundles
//  {Instr1, Instr2, PCA, CIA}. The IF stage pushes a bundle with tQ_IFID_pushReq and throttles on
//  tQ_IFID_full. The ID stage consumes bundles with popReq / empty. FLUSH discards every queued

---
 rtl/q_ifid_queue.sv | 133 +++++++++++++
 tb/tb_q_ifid_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/q_ifid_queue.sv
// IF->ID fetch-bundle FIFO, first-word-fall-through, flushed on redirect.
// Define Q_IFID_ALMOST_FULL_EN to add the almost_full early-warning output.
module q_ifid_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FLUSH,
    input  logic              tQ_IFID_pushReq,
    input  logic [DATA_W-1:0] Instr1_PR,
    input  logic [DATA_W-1:0] Instr2_PR,
    input  logic [DATA_W-1:0] PCA_PR,
    input  logic [DATA_W-1:0] CIA_PR,
    output logic              tQ_IFID_full,
    input  logic              popReq,
    output logic [DATA_W-1:0] Instr1_out,
    output logic [DATA_W-1:0] Instr2_out,
    output logic [DATA_W-1:0] PCA_out,
    output logic [DATA_W-1:0] CIA_out,
    output logic              empty,
    output logic [ADDR_W:0]   count,
`ifdef Q_IFID_ALMOST_FULL_EN
    output logic              almost_full,
`endif
    output logic              overflow
);

    typedef struct packed {
        logic [DATA_W-1:0] instr1;
        logic [DATA_W-1:0] instr2;
        logic [DATA_W-1:0] pca;
        logic [DATA_W-1:0] cia;
    } if_id_t;

    localparam int CW = ADDR_W + 1;
    localparam logic [ADDR_W:0]   CNT_FULL = CW'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = CW'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    if_id_t mem [DEPTH];
    if_id_t wr_b;
    if_id_t head_b;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic full, emp;
    logic go_push, go_pop, drop;

    assign full = (cnt_q == CNT_FULL);
    assign emp  = (cnt_q == '0);

    // FLUSH wins over both handshakes, so gate them here
    assign go_push = tQ_IFID_pushReq & ~full & ~FLUSH;
    assign go_pop  = popReq & ~emp & ~FLUSH;
    assign drop    = tQ_IFID_pushReq & full;

    assign wr_b = '{
        instr1: Instr1_PR,
        instr2: Instr2_PR,
        pca:    PCA_PR,
        cia:    CIA_PR
    };

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q | drop;
        unique case (1'b1)
            FLUSH: begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                cnt_d    = '0;
                ovf_d    = 1'b0;
            end
            (go_push & go_pop): begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            (go_push & ~go_pop): begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                cnt_d    = cnt_q + CNT_ONE;
            end
            (go_pop & ~go_push): begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                cnt_d    = cnt_q - CNT_ONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage carries no reset; emptiness masks stale contents
    always_ff @(posedge CLK) begin
        if (go_push) begin
            mem[wr_ptr_q] <= wr_b;
        end
    end

    assign head_b = emp ? '0 : mem[rd_ptr_q];

    assign Instr1_out   = head_b.instr1;
    assign Instr2_out   = head_b.instr2;
    assign PCA_out      = head_b.pca;
    assign CIA_out      = head_b.cia;
    assign empty        = emp;
    assign tQ_IFID_full = full;
    assign count        = cnt_q;
    assign overflow     = ovf_q;

`ifdef Q_IFID_ALMOST_FULL_EN
    assign almost_full = (cnt_q >= CW'(DEPTH - 1));
`endif

endmodule

// File: tb/tb_q_ifid_queue.sv
// Scoreboard bench for q_ifid_queue: stimulus queues expected bundles,
// a negedge monitor checks the head on every accepted pop.
module tb_q_ifid_queue;

    localparam int DW = 32;
    localparam int AW = 3;

    logic          CLK = 1'b0;
    logic          RESET, FLUSH, pushReq, popReq;
    logic [DW-1:0] i1, i2, pca, cia;
    logic [DW-1:0] o1, o2, opca, ocia;
    logic          full, empty, overflow;
    logic [AW:0]   count;
`ifdef Q_IFID_ALMOST_FULL_EN
    logic          almost_full;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] exp_q [$];

    always #5 CLK = ~CLK;

    q_ifid_queue #(.DATA_W(DW), .DEPTH(8), .ADDR_W(AW)) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .FLUSH           (FLUSH),
        .tQ_IFID_pushReq (pushReq),
        .Instr1_PR       (i1),
        .Instr2_PR       (i2),
        .PCA_PR          (pca),
        .CIA_PR          (cia),
        .tQ_IFID_full    (full),
        .popReq          (popReq),
        .Instr1_out      (o1),
        .Instr2_out      (o2),
        .PCA_out         (opca),
        .CIA_out         (ocia),
        .empty           (empty),
        .count           (count),
`ifdef Q_IFID_ALMOST_FULL_EN
        .almost_full     (almost_full),
`endif
        .overflow        (overflow)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
        end
    endtask

    // Each key k expands to a distinct bundle on all four fields
    function automatic logic [DW-1:0] f2(input logic [DW-1:0] k);
        return ~k;
    endfunction
    function automatic logic [DW-1:0] f3(input logic [DW-1:0] k);
        return k << 2;
    endfunction
    function automatic logic [DW-1:0] f4(input logic [DW-1:0] k);
        return k + 32'd4;
    endfunction

    // Called at posedge+1; leaves at the next posedge+1
    task automatic cyc(input logic psh, input logic [DW-1:0] k,
                       input logic pop, input logic fl, input logic acc);
        pushReq = psh;
        popReq  = pop;
        FLUSH   = fl;
        i1  = k;
        i2  = f2(k);
        pca = f3(k);
        cia = f4(k);
        if (fl) exp_q.delete();
        else if (acc) exp_q.push_back(k);
        @(posedge CLK);
        #1;
        pushReq = 1'b0;
        popReq  = 1'b0;
        FLUSH   = 1'b0;
    endtask

    task automatic chk_st(input string nm, input int c, input logic e,
                          input logic f, input logic ov);
        chk({nm, "_count"}, DW'(count), DW'(c));
        chk({nm, "_empty"}, DW'(empty), DW'(e));
        chk({nm, "_full"}, DW'(full), DW'(f));
        chk({nm, "_overflow"}, DW'(overflow), DW'(ov));
    endtask

    always @(negedge CLK) begin
        logic [DW-1:0] k;
        if (RESET && !FLUSH && popReq && !empty) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_unexpected: got %h, expected no pop", o1);
            end else begin
                k = exp_q.pop_front();
                chk("pop_instr1", o1, k);
                chk("pop_instr2", o2, f2(k));
                chk("pop_pca", opca, f3(k));
                chk("pop_cia", ocia, f4(k));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b0; FLUSH = 1'b0; pushReq = 1'b0; popReq = 1'b0;
        i1 = '0; i2 = '0; pca = '0; cia = '0;
        #3;
        chk_st("reset", 0, 1'b1, 1'b0, 1'b0);
        chk("reset_i1", o1, 32'h0);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;

        // 1: fill to full
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 32'h100 + i, 1'b0, 1'b0, 1'b1);
`ifdef Q_IFID_ALMOST_FULL_EN
            chk("almost_full", DW'(almost_full), DW'(i >= 6));
`endif
        end
        chk_st("fill", 8, 1'b0, 1'b1, 1'b0);
        chk("fill_head", o1, 32'h100);

        // 2: dropped push, then full push+pop, then drain
        cyc(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
        chk_st("drop", 8, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 32'hBEEF, 1'b1, 1'b0, 1'b0);
        chk_st("fullpp", 7, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk_st("drain", 0, 1'b1, 1'b0, 1'b1);
        chk("drain_i1", o1, 32'h0);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk_st("emptypop", 0, 1'b1, 1'b0, 1'b1);

        // 3: push+pop from empty, then steady push+pop
        cyc(1'b1, 32'h300, 1'b1, 1'b0, 1'b1);
        chk_st("epp", 1, 1'b0, 1'b0, 1'b1);
        chk("epp_head", o1, 32'h300);
        cyc(1'b1, 32'h301, 1'b1, 1'b0, 1'b1);
        chk_st("pp", 1, 1'b0, 1'b0, 1'b1);
        chk("pp_head", o1, 32'h301);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);

        // 4: pointer wrap
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h400 + i, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 32'h500 + i, 1'b0, 1'b0, 1'b1);
        chk_st("wrap", 6, 1'b0, 1'b0, 1'b1);
        chk("wrap_head", o1, 32'h500);
        for (int i = 0; i < 6; i++) cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk_st("wrap_end", 0, 1'b1, 1'b0, 1'b1);

        // 5: flush with a same-cycle push
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h600 + i, 1'b0, 1'b0, 1'b1);
        chk_st("preflush", 4, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h5FF, 1'b0, 1'b1, 1'b0);
        chk_st("flush", 0, 1'b1, 1'b0, 1'b0);
        chk("flush_i1", o1, 32'h0);
        chk("flush_i2", o2, 32'h0);
        chk("flush_pca", opca, 32'h0);
        chk("flush_cia", ocia, 32'h0);
`ifdef Q_IFID_ALMOST_FULL_EN
        chk("flush_af", DW'(almost_full), 32'h0);
`endif

        // 6: asynchronous reset between edges
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h700 + i, 1'b0, 1'b0, 1'b1);
        chk_st("prerst", 3, 1'b0, 1'b0, 1'b0);
        #2;
        RESET = 1'b0;
        exp_q.delete();
        #1;
        chk_st("async_rst", 0, 1'b1, 1'b0, 1'b0);
        chk("async_rst_i1", o1, 32'h0);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        cyc(1'b1, 32'h55, 1'b0, 1'b0, 1'b1);
        chk_st("postrst", 1, 1'b0, 1'b0, 1'b0);
        chk("postrst_head", o1, 32'h55);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("sb_drained", DW'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
